lane_align_checker: RTL
=======================

LANE_ALIGN_CHECKER -- requirements
Module: lane_align_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: deserialized word width in bits, legal range 2..8.
REQ-002 SHALL have parameter LANES, default 4: number of independent receive lanes, legal range 1..8.
REQ-003 SHALL have parameter LOCK_COUNT, default 16: consecutive matching words needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_ERRS, default 4: consecutive mismatches in LOCKED that force re-search.
REQ-005 SHALL have parameter SLIP_WAIT, default 3: strobes ignored after each bitslip request (receiver settling).
REQ-006 SHALL have parameter ERR_CNT_W, default 16: width of each per-lane error counter.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port I_STB, input, 1 bit: word-valid strobe common to all lanes and to I_REF.
REQ-010 SHALL have port I_DAT, input, LANES*WIDTH bits: received words; lane n is bits [n*WIDTH +: WIDTH].
REQ-011 SHALL have port I_REF, input, WIDTH bits: expected word, valid with I_STB.
REQ-012 SHALL have port I_CLR, input, 1 bit: clears all counters and FAIL flags; all lanes return to SEARCH.
REQ-013 SHALL have port O_BITSLIP, output, LANES bits: one-cycle bitslip request per lane.
REQ-014 SHALL have port O_LOCKED, output, LANES bits: per-lane lock flag.
REQ-015 SHALL have port O_FAIL, output, LANES bits: sticky per-lane alignment-failure flag.
REQ-016 SHALL have port O_ALL_LOCKED, output, 1 bit: AND of O_LOCKED.
REQ-017 SHALL have port O_ERR_CNT, output, LANES*ERR_CNT_W bits: per-lane saturating error counts, packed like I_DAT.

Function
REQ-018 Each lane SHALL run an independent FSM with states SEARCH, WAIT, CHECK, LOCKED, FAIL; compare = (lane word == I_REF), evaluated only on cycles with I_STB=1.
REQ-019 SEARCH: match -> CHECK, match counter=1; mismatch -> pulse O_BITSLIP, increment slip counter, go to WAIT.
REQ-020 WAIT: count SLIP_WAIT strobes without comparing, then -> SEARCH.
REQ-021 CHECK: match increments match counter, reaching LOCK_COUNT -> LOCKED; mismatch -> pulse O_BITSLIP, increment slip counter, -> WAIT.
REQ-022 LOCKED: O_LOCKED=1; mismatch increments O_ERR_CNT (saturating at all-ones, no wrap) and consecutive-error counter; match clears consecutive-error counter; reaching UNLOCK_ERRS -> SEARCH, O_LOCKED=0, slip counter cleared.
REQ-023 A bitslip SHALL be requested only when the slip counter is below 2*WIDTH; a mismatch at slip count 2*WIDTH -> FAIL instead, O_FAIL=1, no pulse.
REQ-024 Slip counter SHALL clear on entry to LOCKED.
REQ-025 FAIL SHALL be left only by RST or I_CLR.
REQ-026 Each transition, O_BITSLIP pulse and O_LOCKED/O_FAIL/O_ERR_CNT change SHALL be registered, visible the cycle after the triggering strobe; O_BITSLIP high for exactly one cycle.
REQ-027 Lock SHALL be declared the cycle after the LOCK_COUNT-th consecutive matching strobe.
REQ-028 I_CLR with I_STB in the same cycle: I_CLR wins, strobe ignored; I_CLR does not reset O_ERR_CNT saturation logic beyond setting counts to 0.
REQ-029 Cycles with I_STB=0 SHALL not change any state or counter (except I_CLR/RST).
REQ-030 O_ALL_LOCKED SHALL be registered, updated the same cycle as O_LOCKED.

Reset
REQ-031 RST=1 SHALL set all lanes to SEARCH, all counters 0, O_BITSLIP=0, O_LOCKED=0, O_FAIL=0, O_ALL_LOCKED=0, O_ERR_CNT=0; RST overrides I_CLR and I_STB, including mid-lock or mid-WAIT.

Verification
REQ-032 Defaults, all lanes equal I_REF every strobe -> no O_BITSLIP; O_LOCKED=4'hF and O_ALL_LOCKED=1 the cycle after 16th strobe.
REQ-033 Lane 1 word rotated by 3 bits; bench model rotates back by 1 per O_BITSLIP -> exactly 3 pulses on lane 1 only, each followed by 3 ignored strobes, then lock after 16 matches.
REQ-034 Locked lanes, lane 2 corrupted on 2 isolated strobes -> O_ERR_CNT lane 2 = 2, lock retained; 4 consecutive corruptions -> lane 2 unlocks, O_ALL_LOCKED=0.
REQ-035 Lane 0 stuck at 8'h00 with I_REF=8'hA5 -> 16 pulses then O_FAIL[0]=1, no further pulses; I_CLR -> O_FAIL[0]=0, lane 0 in SEARCH.
REQ-036 ERR_CNT_W=4, locked lane mismatching alternate strobes for 40 strobes -> count saturates at 4'hF; RST asserted mid-lock -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lane_align_checker.sv
// -----------------------------------------------------------------------------
// lane_align_checker
//
// Word-alignment checker for a multi-lane deserializer. Every lane compares
// its received word against a common reference word. A lane that does not
// match asks the deserializer to shift its word boundary by one bit
// (O_BITSLIP), waits for the receiver to settle, then tries again. Once
// LOCK_COUNT consecutive words match, the lane is declared locked. While
// locked it counts mismatches, and it re-enters the search after
// UNLOCK_ERRS consecutive errors. A lane that has used up 2*WIDTH bitslips
// without finding alignment parks in FAIL until I_CLR or RST.
//
// Strobe semantics: I_STB is a pure valid qualifier with no back-pressure.
// I_DAT and I_REF are sampled only on rising CLK edges where I_STB=1. Cycles
// without I_STB leave every state and counter untouched, apart from the
// one-cycle O_BITSLIP pulse returning to 0.
//
// Ports
//   CLK          clock; all logic is on its rising edge
//   RST          synchronous active-high reset; overrides I_CLR and I_STB
//   I_STB        word-valid strobe for I_DAT and I_REF
//   I_DAT        received words; lane n is I_DAT[n*WIDTH +: WIDTH]
//   I_REF        expected word
//   I_CLR        clears counters and FAIL flags; returns all lanes to SEARCH
//   O_BITSLIP    one-cycle bitslip request per lane
//   O_LOCKED     per-lane lock flag
//   O_FAIL       sticky per-lane alignment failure flag
//   O_ALL_LOCKED AND of all lock flags (registered)
//   O_ERR_CNT    per-lane saturating mismatch counts while locked
//   O_DBG_STATE  per-lane FSM state, 3 bits per lane, packed like I_DAT
// -----------------------------------------------------------------------------
module lane_align_checker #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 4,
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int SLIP_WAIT   = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       I_STB,
    input  logic [LANES*WIDTH-1:0]     I_DAT,
    input  logic [WIDTH-1:0]           I_REF,
    input  logic                       I_CLR,
    output logic [LANES-1:0]           O_BITSLIP,
    output logic [LANES-1:0]           O_LOCKED,
    output logic [LANES-1:0]           O_FAIL,
    output logic                       O_ALL_LOCKED,
    output logic [LANES*ERR_CNT_W-1:0] O_ERR_CNT,
    output logic [LANES*3-1:0]         O_DBG_STATE
);

    typedef enum logic [2:0] {
        ST_SEARCH = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } lane_state_t;

    // Counter widths sized to hold their largest reachable value.
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(2 * WIDTH + 1);
    localparam int WW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int CW = $clog2(UNLOCK_ERRS + 1);

    // The "_LAST" values identify the strobe that completes each count.
    localparam logic [MW-1:0]        LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0]        SLIP_MAX  = SW'(2 * WIDTH);
    localparam logic [WW-1:0]        WAIT_LAST = WW'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);
    localparam logic [CW-1:0]        UNL_LAST  = CW'(UNLOCK_ERRS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    // With no settling time, a bitslip goes straight back to SEARCH.
    localparam lane_state_t SLIP_STATE = (SLIP_WAIT > 0) ? ST_WAIT : ST_SEARCH;

    logic [LANES-1:0] w_locked_nxt_all;
    logic             r_all_locked;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [WIDTH-1:0]     w_word;
        logic                 w_match;
        logic                 w_can_slip;
        logic                 w_locked_nxt;

        lane_state_t          r_state;
        logic [MW-1:0]        r_match_cnt;
        logic [SW-1:0]        r_slip_cnt;
        logic [WW-1:0]        r_wait_cnt;
        logic [CW-1:0]        r_cerr_cnt;
        logic [ERR_CNT_W-1:0] r_err_cnt;
        logic                 r_bitslip;
        logic                 r_locked;
        logic                 r_fail;

        assign w_word     = I_DAT[n*WIDTH +: WIDTH];
        assign w_match    = (w_word == I_REF);
        assign w_can_slip = (r_slip_cnt < SLIP_MAX);

        // Next value of the lock flag. It is used both by the lane register
        // and by the all-locked register, so both update on the same edge.
        always_comb begin
            w_locked_nxt = r_locked;
            if (RST || I_CLR) begin
                w_locked_nxt = 1'b0;
            end else if (I_STB) begin
                case (r_state)
                    ST_SEARCH: if (w_match && (LOCK_COUNT <= 1))              w_locked_nxt = 1'b1;
                    ST_CHECK:  if (w_match && (r_match_cnt == LOCK_LAST))     w_locked_nxt = 1'b1;
                    ST_LOCKED: if (!w_match && (r_cerr_cnt == UNL_LAST))      w_locked_nxt = 1'b0;
                    default:   ;
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (RST || I_CLR) begin
                r_state     <= ST_SEARCH;
                r_match_cnt <= '0;
                r_slip_cnt  <= '0;
                r_wait_cnt  <= '0;
                r_cerr_cnt  <= '0;
                r_err_cnt   <= '0;
                r_bitslip   <= 1'b0;
                r_locked    <= 1'b0;
                r_fail      <= 1'b0;
            end else begin
                r_bitslip <= 1'b0;
                r_locked  <= w_locked_nxt;
                if (I_STB) begin
                    case (r_state)
                        ST_SEARCH, ST_CHECK: begin
                            if (w_match) begin
                                if ((r_state == ST_SEARCH) && (LOCK_COUNT > 1)) begin
                                    r_state     <= ST_CHECK;
                                    r_match_cnt <= MW'(1);
                                end else if ((r_state == ST_SEARCH) || (r_match_cnt == LOCK_LAST)) begin
                                    r_state     <= ST_LOCKED;
                                    r_match_cnt <= '0;
                                    r_slip_cnt  <= '0;
                                    r_cerr_cnt  <= '0;
                                end else begin
                                    r_match_cnt <= r_match_cnt + 1'b1;
                                end
                            end else if (w_can_slip) begin
                                r_bitslip   <= 1'b1;
                                r_slip_cnt  <= r_slip_cnt + 1'b1;
                                r_wait_cnt  <= '0;
                                r_match_cnt <= '0;
                                r_state     <= SLIP_STATE;
                            end else begin
                                // Every bit offset has been tried: give up.
                                r_state <= ST_FAIL;
                                r_fail  <= 1'b1;
                            end
                        end
                        ST_WAIT: begin
                            // Strobes here are counted but not compared.
                            if (r_wait_cnt == WAIT_LAST) begin
                                r_state    <= ST_SEARCH;
                                r_wait_cnt <= '0;
                            end else begin
                                r_wait_cnt <= r_wait_cnt + 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            if (w_match) begin
                                r_cerr_cnt <= '0;
                            end else begin
                                if (r_err_cnt != ERR_MAX) begin
                                    r_err_cnt <= r_err_cnt + 1'b1;
                                end
                                if (r_cerr_cnt == UNL_LAST) begin
                                    r_state    <= ST_SEARCH;
                                    r_cerr_cnt <= '0;
                                    r_slip_cnt <= '0;
                                end else begin
                                    r_cerr_cnt <= r_cerr_cnt + 1'b1;
                                end
                            end
                        end
                        ST_FAIL: ;
                        default: r_state <= ST_SEARCH;
                    endcase
                end
            end
        end

        assign w_locked_nxt_all[n]                     = w_locked_nxt;
        assign O_BITSLIP[n]                            = r_bitslip;
        assign O_LOCKED[n]                             = r_locked;
        assign O_FAIL[n]                               = r_fail;
        assign O_ERR_CNT[n*ERR_CNT_W +: ERR_CNT_W]     = r_err_cnt;
        assign O_DBG_STATE[n*3 +: 3]                   = r_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &w_locked_nxt_all;
        end
    end

    assign O_ALL_LOCKED = r_all_locked;

endmodule
